// File: rtl/lvt_ram_multiport.sv
// lvt_ram_multiport: NR-read / NW-write RAM built from per-port banks and a live-value table
module lvt_ram_multiport #(
    parameter int NR     = 8,
    parameter int NW     = 8,
    parameter int DW     = 32,
    parameter int AW     = 11,
    parameter int BYPASS = 0,
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW*AW-1:0] w_addr,
    input  logic [NW*DW-1:0] w_din,
    input  logic [NW-1:0]    w_enb,
    input  logic [NR*AW-1:0] r_addr,
    output logic [NR*DW-1:0] r_dout,
    output logic             ready,
    output logic             w_conflict
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_addr;
    logic          run;
    logic          conflict;
    logic [DW-1:0] bank [NW][DEPTH];
    logic [LW-1:0] lvt [DEPTH];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] rd [NR];

    for (genvar i = 0; i < NW; i++) begin : g_wr
        assign wa[i] = w_addr[i*AW +: AW];
        assign wd[i] = w_din[i*DW +: DW];
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        assign ra[j] = r_addr[j*AW +: AW];
    end

    assign run   = state_q == RUN;
    assign ready = run;

    // Leave INIT once the last address has been cleared
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_addr == '1) state_d = RUN;
    end

    // State register and the clearing address counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            init_addr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_addr <= init_addr + 1'b1;
        end
    end

    // Banks and LVT: cleared during INIT; in RUN the ascending loop lets the highest port own the LVT entry
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int i = 0; i < NW; i++) bank[i][init_addr] <= '0;
            lvt[init_addr] <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (w_enb[i]) begin
                    bank[i][wa[i]] <= wd[i];
                    lvt[wa[i]]     <= LW'(i);
                end
            end
        end
    end

    // Collision detect and per-port read selection through the LVT, with optional same-cycle forwarding
    always_comb begin
        conflict = 1'b0;
        rd       = '{default: '0};
        for (int i = 0; i < NW; i++) begin
            for (int k = i + 1; k < NW; k++) begin
                if (w_enb[i] && w_enb[k] && wa[i] == wa[k]) conflict = 1'b1;
            end
        end
        for (int j = 0; j < NR; j++) begin
            rd[j] = bank[0][ra[j]];
            for (int i = 1; i < NW; i++) begin
                if (lvt[ra[j]] == LW'(i)) rd[j] = bank[i][ra[j]];
            end
            if (BYPASS != 0) begin
                for (int i = 0; i < NW; i++) begin
                    if (w_enb[i] && wa[i] == ra[j]) rd[j] = wd[i];
                end
            end
        end
    end

    // Registered read data and conflict pulse, forced to zero outside RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout     <= '0;
            w_conflict <= 1'b0;
        end else begin
            w_conflict <= run & conflict;
            for (int j = 0; j < NR; j++) r_dout[j*DW +: DW] <= run ? rd[j] : '0;
        end
    end
endmodule
